iterative_shifter: RTL and testbench
====================================

# iterative_shifter

Multi-cycle, parameterised shift unit for the processor's execute stage. It generalises the fixed arithmetic-right-by-8 shifter to any shift amount and direction. It supports logical left, logical right, arithmetic right and optional rotate right, and processes one shift-amount bit per clock from MSB to LSB. The integer ALU issues operations to it with a start/ready/done handshake and stalls until done.

## Interface
- WIDTH, 32: operand/result width in bits. Must be a power of two, ≥ 2.
- SHAMT_W, $clog2(WIDTH): shift-amount width. Fixed by WIDTH; not overridden.
- clock  input  1  sole clock; all logic is sampled on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- operand  input  WIDTH  value to shift; captured on the accepted start.
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1; captured on the accepted start.
- mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration); captured on the accepted start.
- ready  output  1  idle, able to accept start.
- done  output  1  one-cycle pulse: result is valid.
- result  output  WIDTH  shifted value; holds until the next completion or reset.

## Operation
- States: IDLE, SHIFT.
- IDLE, ready=1:
  - start=1 and shamt==0: result<=operand, done<=1, stay in IDLE (early-out).
  - start=1 and shamt!=0: latch operand into the work register; latch shamt, mode and the sign bit operand[WIDTH-1]; bit index k<=SHAMT_W-1; go to SHIFT.
- SHIFT, ready=0: each cycle, if shamt[k]=1, shift the work register by 2^k according to mode.
  - SLL fills zeros at the LSB end.
  - SRL fills zeros at the MSB end.
  - SRA fills with the latched sign bit.
  - ROR wraps the low 2^k bits to the top.
  - If shamt[k]=0, the work register holds. Then k<=k-1.
  - When k==0: result<=final value, done<=1, go to IDLE.
- Sign is taken from the original operand, never re-derived mid-operation.
- start while ready=0 is ignored; there is no queueing and no error.
- Inputs are don't-care after capture and may change freely during SHIFT.
- Reset: state<=IDLE, ready=1, done=0, result=0, work register=0, k=SHAMT_W-1.
  - Reset during SHIFT aborts the operation. No done is produced for it.
- Arithmetic is width-exact. Bits shifted out are discarded; there is no carry or overflow output.

## Timing
- Start is sampled in cycle 0.
- shamt==0: done=1 and result valid in cycle 1; ready stays 1 throughout.
- shamt!=0:
  - ready=0 in cycles 1..SHAMT_W.
  - done=1 and ready=1 in cycle SHAMT_W+1. This is cycle 6 for WIDTH=32.
  - Latency is fixed and independent of the shamt value.
- A new start is accepted in the same cycle done is high (back-to-back issue).
  - Throughput: one op per SHAMT_W+1 cycles, or one per cycle for shamt==0.
- done is high for exactly one cycle per accepted start.
- result changes only on the edge that raises done, or on reset.
- reset=1 takes priority over start in the same cycle.

## Configuration
- Macro: ITERATIVE_SHIFTER_ROTATE_EN.
- Defined: mode 11 performs rotate right by shamt.
- Undefined: mode 11 is decoded as SRL (zero fill), and the rotate datapath is not built. All other modes and all timing are identical.

## Test plan
- WIDTH=32, SRA, operand 0x80000000, shamt 8 -> done in cycle 6, result 0xFF800000. Same operand with SRL -> 0x00800000.
- SLL, operand 0x00000001, shamt 31 -> result 0x80000000. SLL, operand 0xFFFFFFFF, shamt 1 -> 0xFFFFFFFE.
- Any mode, shamt 0, operand 0x12345678 -> done in cycle 1, result 0x12345678, ready never drops.
- With ITERATIVE_SHIFTER_ROTATE_EN: mode 11, operand 0x000000F1, shamt 4 -> result 0x1000000F. Without the macro: same stimulus -> 0x0000000F.
- Busy and back-to-back:
  - Pulse start with new values during cycles 1..5 -> ignored; one done only.
  - Issue a second op in the done cycle -> accepted; its done arrives 6 cycles later.
- Reset abort: start SRA 0x80000000 by 8, assert reset in cycle 3 -> no done, result 0, ready=1 the cycle after reset. A fresh op after reset completes correctly.

Source files
------------

// File: rtl/iterative_shifter_if.sv
// Start/ready/done handshake bundle between the integer ALU and the
// iterative shifter. The ALU side uses the master modport, the shifter
// side uses the slave modport.
interface iterative_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               start;
    logic [WIDTH-1:0]   operand;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         mode;
    logic               ready;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, operand, shamt, mode,
        input  ready, done, result
    );

    modport slave (
        input  start, operand, shamt, mode,
        output ready, done, result
    );
endinterface

// File: rtl/iterative_shifter.sv
// Multi-cycle shift unit for the execute stage. One shift-amount bit is
// consumed per clock, MSB first, so latency is SHAMT_W+1 cycles regardless
// of the shift amount; a zero shift amount completes in one cycle.
// Modes: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
// Optional feature macro: ITERATIVE_SHIFTER_ROTATE_EN. When it is undefined
// mode 11 behaves as SRL and no rotate datapath is built.
module iterative_shifter #(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    iterative_shifter_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] K_TOP = SHAMT_W'(SHAMT_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   work_step;
    logic [WIDTH-1:0]   result_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [SHAMT_W-1:0] k;
    mode_t              mode_q;
    logic               sign_q;
    logic               done_q;
    logic               early;
    logic               load;
    logic               last;
    int unsigned        step_n;

    assign bus.ready  = (state == IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

    // Next-state and control decode: accept a start in IDLE, finish at k==0.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_next = state;
        early      = 1'b0;
        load       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.shamt == '0) begin
                        early = 1'b1;
                    end else begin
                        load       = 1'b1;
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (k == '0) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset wins over any start in the same cycle.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values together.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // One shift step of 2^k positions, applied only when shamt bit k is set.
    always_comb begin
        step_n    = 32'd1 << k;
        work_step = work;
        if (shamt_q[k]) begin
            case (mode_q)
                MODE_SLL: work_step = work << step_n;
                MODE_SRA: work_step = (work >> step_n)
                                    | ({WIDTH{sign_q}} & ~({WIDTH{1'b1}} >> step_n));
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
                MODE_ROR: work_step = (work >> step_n) | (work << (WIDTH - step_n));
`endif
                default:  work_step = work >> step_n;
            endcase
        end
    end

    // Operand capture, per-cycle work update and result/done registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            work     <= '0;
            shamt_q  <= '0;
            mode_q   <= MODE_SLL;
            sign_q   <= 1'b0;
            k        <= K_TOP;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (early) begin
                result_q <= bus.operand;
                done_q   <= 1'b1;
            end
            if (load) begin
                work    <= bus.operand;
                shamt_q <= bus.shamt;
                mode_q  <= mode_t'(bus.mode);
                // Sign comes from the original operand, never from the work register.
                sign_q  <= bus.operand[WIDTH-1];
                k       <= K_TOP;
            end
            if (state == SHIFT) begin
                work <= work_step;
                k    <= k - SHAMT_W'(1);
                if (last) begin
                    result_q <= work_step;
                    done_q   <= 1'b1;
                    k        <= K_TOP;
                end
            end
        end
    end
endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter (WIDTH=32). Expected results are
// queued when an operation is accepted and compared when done pulses.
// Compile with ITERATIVE_SHIFTER_ROTATE_EN to match a rotate-enabled build.
module tb_iterative_shifter;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] op;
        logic [4:0]  sh;
        logic [1:0]  md;
        logic [31:0] ex;
    } vec_t;

`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    localparam logic [31:0] ROT_EXP = 32'h1000_000F;
`else
    localparam logic [31:0] ROT_EXP = 32'h0000_000F;
`endif

    logic        clock;
    logic        reset;
    int          cyc;
    int          checks;
    int          failures;
    logic        mon_en;
    logic [31:0] drv_exp;
    exp_t        sb[$];

    iterative_shifter_if #(.WIDTH(WIDTH)) bus ();

    iterative_shifter #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] op, input logic [4:0] sh,
                                              input logic [1:0] md);
        logic signed [31:0] s;
        s = op;
        case (md)
            2'b00: return op << sh;
            2'b10: return s >>> sh;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
            2'b11: return (op >> sh) | (op << (32 - int'(sh)));
`endif
            default: return op >> sh;
        endcase
    endfunction

    // Issue one operation: wait (bounded) for ready, hold start for one cycle.
    task automatic issue(input logic [31:0] op, input logic [4:0] sh, input logic [1:0] md,
                         input logic [31:0] ex);
        int n = 0;
        while (bus.ready !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
        bus.start   = 1'b1;
        bus.operand = op;
        bus.shamt   = sh;
        bus.mode    = md;
        drv_exp     = ex;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    // Monitor: reference ready/busy model, scoreboard pop on done, result hold.
    initial begin
        int          busy_left = 0;
        logic [31:0] hold = '0;
        logic        model_ready;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                model_ready = (busy_left == 0);
                check("ready", {31'd0, bus.ready}, {31'd0, model_ready});
                if (bus.done === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("spurious_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("done_cycle", cyc, e.cyc);
                        check("result", bus.result, e.res);
                        hold = e.res;
                    end
                end else begin
                    check("result_hold", bus.result, hold);
                end
                if (reset) begin
                    sb.delete();
                    busy_left = 0;
                    hold      = '0;
                end else if (bus.start && model_ready) begin
                    sb.push_back('{drv_exp, cyc + ((bus.shamt == '0) ? 1 : SHAMT_W + 1)});
                    busy_left = (bus.shamt == '0) ? 0 : SHAMT_W;
                end else if (busy_left > 0) begin
                    busy_left--;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        logic [31:0] op;
        logic [4:0]  sh;
        logic [1:0]  md;
        int          n;

        checks      = 0;
        failures    = 0;
        cyc         = 0;
        mon_en      = 1'b0;
        drv_exp     = '0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.operand = '0;
        bus.shamt   = '0;
        bus.mode    = '0;

        @(posedge clock); #1;
        mon_en = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;

        // Directed vectors; consecutive nonzero-shift ops issue in the done cycle.
        vecs.push_back('{32'h8000_0000, 5'd8,  2'b10, 32'hFF80_0000});
        vecs.push_back('{32'h8000_0000, 5'd8,  2'b01, 32'h0080_0000});
        vecs.push_back('{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000});
        vecs.push_back('{32'hFFFF_FFFF, 5'd1,  2'b00, 32'hFFFF_FFFE});
        vecs.push_back('{32'h7FFF_FFFF, 5'd4,  2'b10, 32'h07FF_FFFF});
        vecs.push_back('{32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678});
        vecs.push_back('{32'h1234_5678, 5'd0,  2'b01, 32'h1234_5678});
        vecs.push_back('{32'h1234_5678, 5'd0,  2'b10, 32'h1234_5678});
        vecs.push_back('{32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678});
        vecs.push_back('{32'h0000_00F1, 5'd4,  2'b11, ROT_EXP});
        vecs.push_back('{32'h8000_0001, 5'd31, 2'b10, 32'hFFFF_FFFF});
        foreach (vecs[i]) issue(vecs[i].op, vecs[i].sh, vecs[i].md, vecs[i].ex);

        // Starts pulsed while busy must be ignored.
        issue(32'hC000_0000, 5'd3, 2'b10, 32'hF800_0000);
        for (int i = 0; i < SHAMT_W; i++) begin
            bus.start   = 1'b1;
            bus.operand = $urandom;
            bus.shamt   = 5'($urandom_range(1, 31));
            bus.mode    = 2'($urandom_range(0, 3));
            drv_exp     = 32'hDEAD_BEEF;
            @(posedge clock); #1;
        end
        bus.start = 1'b0;

        // Reset in cycle 3 aborts the operation with no done.
        issue(32'h8000_0000, 5'd8, 2'b10, 32'hFF80_0000);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        issue(32'h8000_0000, 5'd8, 2'b10, 32'hFF80_0000);

        // Random operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            op = $urandom;
            sh = (i % 4 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            md = 2'($urandom_range(0, 3));
            issue(op, sh, md, ref_shift(op, sh, md));
        end

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check("drain", sb.size(), 32'd0);
        repeat (3) @(posedge clock);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
